// File: rtl/usb_host_trans_seq_pkg.sv
// Shared constants, register map and state encodings for the usbHost
// transaction sequencer.
package usb_host_seq_pkg;

  localparam logic [7:0] REG_TX_CONTROL    = 8'h00;
  localparam logic [7:0] REG_TX_TRANS_TYPE = 8'h01;
  localparam logic [7:0] REG_TX_ADDR       = 8'h04;
  localparam logic [7:0] REG_TX_ENDP       = 8'h05;
  localparam logic [7:0] REG_INT_STATUS    = 8'h08;
  localparam logic [7:0] REG_RX_STATUS     = 8'h0A;

  localparam logic [7:0] TRANS_REQ      = 8'h01;
  localparam logic [7:0] TRANS_DONE_BIT = 8'h01;

  localparam logic [7:0] ERR_ACK  = 8'hFF;
  localparam logic [7:0] ERR_DONE = 8'hFE;

  typedef enum logic [1:0] {
    TT_SETUP    = 2'd0,
    TT_IN       = 2'd1,
    TT_OUTDATA0 = 2'd2,
    TT_OUTDATA1 = 2'd3
  } trans_type_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_ENDP,
    ST_WR_TYPE,
    ST_WR_CTRL,
    ST_WAIT_DONE,
    ST_RD_STATUS,
    ST_CLR_INT,
    ST_RESP
  } seq_state_e;

  typedef enum logic [1:0] {
    BI_IDLE,
    BI_STROBE,
    BI_GAP
  } busif_state_e;

  typedef struct packed {
    trans_type_e ttype;
    logic [3:0]  endp;
  } cmd_t;

  function automatic logic is_bus_state(seq_state_e s);
    return s inside {ST_WR_ADDR, ST_WR_ENDP, ST_WR_TYPE, ST_WR_CTRL,
                     ST_RD_STATUS, ST_CLR_INT};
  endfunction

endpackage

// File: rtl/usb_host_trans_seq_if.sv
// usbHost 8-bit strobe/ack register bus.
interface usb_host_trans_seq_if;
  logic [7:0] m_address;
  logic [7:0] m_data_wr;
  logic [7:0] m_data_rd;
  logic       m_we;
  logic       m_strobe;
  logic       m_ack;

  modport master (output m_address, m_data_wr, m_we, m_strobe,
                  input  m_data_rd, m_ack);
  modport slave  (input  m_address, m_data_wr, m_we, m_strobe,
                  output m_data_rd, m_ack);
endinterface

// File: rtl/usb_host_trans_seq_busif.sv
// Single-access strobe/ack engine: holds one access until ack or ack timeout,
// then spends one gap cycle reporting done/timeout.
module usb_host_seq_busif
  import usb_host_seq_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       done_o,
  output logic       timeout_o,
  output logic [7:0] rdata_o,
  usb_host_trans_seq_if.master bus
);

  localparam int unsigned ACW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  busif_state_e   bst_q, bst_d;
  logic [7:0]     addr_q, addr_d;
  logic [7:0]     wdata_q, wdata_d;
  logic           we_q, we_d;
  logic [ACW-1:0] cnt_q, cnt_d;
  logic           to_q, to_d;
  logic [7:0]     rdata_q, rdata_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bst_q   <= BI_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      bst_q   <= bst_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    bst_d   = bst_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    rdata_d = rdata_q;
    unique case (bst_q)
      BI_IDLE, BI_GAP: begin
        if (start_i) begin
          bst_d   = BI_STROBE;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          we_d    = we_i;
          cnt_d   = '0;
          to_d    = 1'b0;
        end else begin
          bst_d = BI_IDLE;
        end
      end
      BI_STROBE: begin
        // Ack beats timeout when both land on the last permitted cycle.
        if (bus.m_ack) begin
          bst_d = BI_GAP;
          to_d  = 1'b0;
          if (!we_q) rdata_d = bus.m_data_rd;
        end else if (cnt_q == ACW'(ACK_TIMEOUT - 1)) begin
          bst_d = BI_GAP;
          to_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: bst_d = BI_IDLE;
    endcase
  end

  always_comb begin
    bus.m_strobe  = (bst_q == BI_STROBE);
    bus.m_address = bus.m_strobe ? addr_q : '0;
    bus.m_we      = bus.m_strobe && we_q;
    bus.m_data_wr = (bus.m_strobe && we_q) ? wdata_q : '0;
    done_o        = (bst_q == BI_GAP) && !to_q;
    timeout_o     = (bst_q == BI_GAP) && to_q;
    rdata_o       = rdata_q;
  end

endmodule

// File: rtl/usb_host_trans_seq.sv
// Runs one usbHost transaction per command: program addr/endp/type, kick,
// wait for trans-done, read RX status, clear the interrupt, respond.
module usb_host_trans_seq
  import usb_host_seq_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT  = 15,
  parameter int unsigned DONE_TIMEOUT = 65535,
  parameter int unsigned DONE_CNT_W   = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [1:0] cmd_type_i,
  input  logic [6:0] cmd_addr_i,
  input  logic [3:0] cmd_endp_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_status_o,
  output logic       rsp_timeout_o,
  input  logic       trans_done_i,
  usb_host_trans_seq_if.master m_bus
);

  seq_state_e            state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [DONE_CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic [7:0]            rsp_status_q, rsp_status_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic       bus_start, bus_we, bus_done, bus_timeout;
  logic [7:0] bus_addr, bus_wdata, bus_rdata;

  usb_host_seq_busif #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_busif (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (bus_start),
    .we_i      (bus_we),
    .addr_i    (bus_addr),
    .wdata_i   (bus_wdata),
    .done_o    (bus_done),
    .timeout_o (bus_timeout),
    .rdata_o   (bus_rdata),
    .bus       (m_bus)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      cmd_q         <= '0;
      done_cnt_q    <= '0;
      rsp_status_q  <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      done_cnt_q    <= done_cnt_d;
      rsp_status_q  <= rsp_status_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    done_cnt_d = (state_q == ST_WAIT_DONE) ? done_cnt_q + 1'b1 : '0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          state_d = ST_WR_ADDR;
          cmd_d   = '{ttype: trans_type_e'(cmd_type_i), endp: cmd_endp_i};
        end
      end
      ST_WR_ADDR:   if (bus_timeout) state_d = ST_RESP; else if (bus_done) state_d = ST_WR_ENDP;
      ST_WR_ENDP:   if (bus_timeout) state_d = ST_RESP; else if (bus_done) state_d = ST_WR_TYPE;
      ST_WR_TYPE:   if (bus_timeout) state_d = ST_RESP; else if (bus_done) state_d = ST_WR_CTRL;
      ST_WR_CTRL:   if (bus_timeout) state_d = ST_RESP; else if (bus_done) state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (trans_done_i) state_d = ST_RD_STATUS;
        else if (done_cnt_q == DONE_CNT_W'(DONE_TIMEOUT)) state_d = ST_RESP;
      end
      ST_RD_STATUS: if (bus_timeout) state_d = ST_RESP; else if (bus_done) state_d = ST_CLR_INT;
      ST_CLR_INT:   if (bus_timeout || bus_done) state_d = ST_RESP;
      ST_RESP:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // The access for a bus state is launched on the cycle that decides to enter
  // it, so its strobe is already up on the state's first cycle.
  always_comb begin
    cmd_ready_o = (state_q == ST_IDLE);
    rsp_valid_o = (state_q == ST_RESP);
    bus_start   = is_bus_state(state_d) && (state_d != state_q);
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_wdata   = '0;
    unique case (state_d)
      ST_WR_ADDR:   begin bus_we = 1'b1; bus_addr = REG_TX_ADDR;       bus_wdata = {1'b0, cmd_addr_i};       end
      ST_WR_ENDP:   begin bus_we = 1'b1; bus_addr = REG_TX_ENDP;       bus_wdata = {4'b0, cmd_q.endp};       end
      ST_WR_TYPE:   begin bus_we = 1'b1; bus_addr = REG_TX_TRANS_TYPE; bus_wdata = {6'b0, cmd_q.ttype};      end
      ST_WR_CTRL:   begin bus_we = 1'b1; bus_addr = REG_TX_CONTROL;    bus_wdata = TRANS_REQ;                end
      ST_RD_STATUS: begin bus_we = 1'b0; bus_addr = REG_RX_STATUS;     bus_wdata = '0;                       end
      ST_CLR_INT:   begin bus_we = 1'b1; bus_addr = REG_INT_STATUS;    bus_wdata = TRANS_DONE_BIT;           end
      default:      ;
    endcase

    rsp_status_d  = rsp_status_q;
    rsp_timeout_d = rsp_timeout_q;
    if ((state_d == ST_RESP) && (state_q != ST_RESP)) begin
      if (bus_timeout) begin
        rsp_status_d  = ERR_ACK;
        rsp_timeout_d = 1'b1;
      end else if (state_q == ST_WAIT_DONE) begin
        rsp_status_d  = ERR_DONE;
        rsp_timeout_d = 1'b1;
      end else begin
        rsp_status_d  = bus_rdata;
        rsp_timeout_d = 1'b0;
      end
    end
  end

  assign rsp_status_o  = rsp_status_q;
  assign rsp_timeout_o = rsp_timeout_q;

endmodule
